// File: rtl/mdrp_pkg.sv
// Shared constants and types for the MDRP responder: opcodes, data width and lock FSM states.
package mdrp_pkg;

    localparam int unsigned MDRP_DW = 8;

    localparam logic [1:0] MDRP_OP_NOP     = 2'b00;
    localparam logic [1:0] MDRP_OP_WRITE   = 2'b01;
    localparam logic [1:0] MDRP_OP_READ    = 2'b10;
    localparam logic [1:0] MDRP_OP_SETADDR = 2'b11;

    typedef enum logic [0:0] {
        ST_RELOCK,
        ST_LOCKED
    } lock_state_e;

    function automatic logic addr_in_range(input logic [MDRP_DW-1:0] addr,
                                           input int unsigned num_regs);
        return 32'(addr) < num_regs;
    endfunction

endpackage

// File: rtl/mdrp_lock_timer.sv
// Emulated PLL lock: lock stays low for LOCK_DELAY cycles after reset or restart, then rises.
module mdrp_lock_timer
    import mdrp_pkg::*;
#(
    parameter int unsigned LOCK_DELAY = 16
) (
    input  logic mdclk,
    input  logic reset,
    input  logic restart,
    output logic lock,
    output logic done
);

    localparam int unsigned CW = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LOCK_DELAY - 1);

    lock_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lock_q, lock_d;
    logic          done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (restart) begin
            state_d = ST_RELOCK;
            cnt_d   = CNT_INIT;
        end else begin
            case (state_q)
                ST_RELOCK: begin
                    if (cnt_q == '0) begin
                        state_d = ST_LOCKED;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // Outputs follow the next state so they are registered alongside it.
        lock_d = (state_d == ST_LOCKED);
        done_d = (state_q == ST_RELOCK) && (state_d == ST_LOCKED);
    end

    always_ff @(posedge mdclk) begin
        if (reset) begin
            state_q <= ST_RELOCK;
            cnt_q   <= CNT_INIT;
            lock_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
            done_q  <= done_d;
        end
    end

    assign lock = lock_q;
    assign done = done_q;

endmodule

// File: rtl/mdrp_responder.sv
// PLL-side MDRP responder: config register file, address pointer, emulated lock and side read port.
// Optional sticky error output enabled by defining MDRP_RESPONDER_ERR_EN.
module mdrp_responder
    import mdrp_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 32,
    parameter logic [7:0]  COMMIT_ADDR = 8'h1F,
    parameter int unsigned LOCK_DELAY  = 16
) (
    input  logic       mdclk,
    input  logic       reset,
    input  logic [1:0] mdopc,
    input  logic       mdainc,
    input  logic [7:0] mdwdi,
    output logic [7:0] mdrdo,
    output logic       lock,
    output logic       cfg_changed,
`ifdef MDRP_RESPONDER_ERR_EN
    output logic       err,
`endif
    input  logic [7:0] cfg_addr,
    output logic [7:0] cfg_data
);

    localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [MDRP_DW-1:0] regs_q [NUM_REGS];
    logic [MDRP_DW-1:0] regs_d [NUM_REGS];
    logic [7:0]         ptr_q, ptr_d;
    logic [7:0]         mdrdo_q, mdrdo_d;
    logic [7:0]         cfg_data_q, cfg_data_d;
    logic               cfg_changed_q, cfg_changed_d;
    logic               ptr_in_range;
    logic               commit;
    logic               unused_lock_done;

    function automatic logic [7:0] read_reg(input logic [7:0] addr);
        if (addr_in_range(addr, NUM_REGS)) begin
            return regs_q[addr[IW-1:0]];
        end
        return '0;
    endfunction

    always_comb begin
        regs_d       = regs_q;
        ptr_d        = ptr_q;
        mdrdo_d      = mdrdo_q;
        ptr_in_range = addr_in_range(ptr_q, NUM_REGS);
        case (mdopc)
            MDRP_OP_WRITE: begin
                if (ptr_in_range) begin
                    regs_d[ptr_q[IW-1:0]] = mdwdi;
                end
                if (mdainc) begin
                    ptr_d = ptr_q + 8'd1;
                end
            end
            MDRP_OP_READ: begin
                mdrdo_d = read_reg(ptr_q);
                if (mdainc) begin
                    ptr_d = ptr_q + 8'd1;
                end
            end
            MDRP_OP_SETADDR: ptr_d = mdwdi;
            default: ;
        endcase
        // An out-of-range COMMIT_ADDR can never be in range, so commits never fire.
        commit = (mdopc == MDRP_OP_WRITE) && ptr_in_range && (ptr_q == COMMIT_ADDR) && mdwdi[0];
        cfg_changed_d = commit;
        cfg_data_d    = read_reg(cfg_addr);
    end

    always_ff @(posedge mdclk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            ptr_q         <= '0;
            mdrdo_q       <= '0;
            cfg_data_q    <= '0;
            cfg_changed_q <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            ptr_q         <= ptr_d;
            mdrdo_q       <= mdrdo_d;
            cfg_data_q    <= cfg_data_d;
            cfg_changed_q <= cfg_changed_d;
        end
    end

    mdrp_lock_timer #(
        .LOCK_DELAY(LOCK_DELAY)
    ) u_lock_timer (
        .mdclk  (mdclk),
        .reset  (reset),
        .restart(commit),
        .lock   (lock),
        .done   (unused_lock_done)
    );

`ifdef MDRP_RESPONDER_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (((mdopc == MDRP_OP_WRITE) || (mdopc == MDRP_OP_READ)) &&
            !addr_in_range(ptr_q, NUM_REGS)) begin
            err_d = 1'b1;
        end
        if ((mdopc == MDRP_OP_SETADDR) && !lock) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge mdclk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    assign mdrdo       = mdrdo_q;
    assign cfg_data    = cfg_data_q;
    assign cfg_changed = cfg_changed_q;

endmodule

// File: tb/tb_mdrp_responder.sv
// Scoreboard bench for mdrp_responder: stimulus queues cycle-tagged expectations, a monitor checks them.
module tb_mdrp_responder;
    import mdrp_pkg::*;

    logic       mdclk = 1'b0;
    logic       reset;
    logic [1:0] mdopc;
    logic       mdainc;
    logic [7:0] mdwdi;
    logic [7:0] mdrdo;
    logic       lock;
    logic       cfg_changed;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_data;
`ifdef MDRP_RESPONDER_ERR_EN
    logic       err;
`endif

    mdrp_responder dut (
        .mdclk      (mdclk),
        .reset      (reset),
        .mdopc      (mdopc),
        .mdainc     (mdainc),
        .mdwdi      (mdwdi),
        .mdrdo      (mdrdo),
        .lock       (lock),
        .cfg_changed(cfg_changed),
`ifdef MDRP_RESPONDER_ERR_EN
        .err        (err),
`endif
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data)
    );

    always #5 mdclk = ~mdclk;

    // Signal selectors for scoreboard entries.
    localparam int SIG_RDO = 0;
    localparam int SIG_LOCK = 1;
    localparam int SIG_CHG = 2;
    localparam int SIG_CFG = 3;
    localparam int SIG_ERR = 4;

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] act;

    always @(posedge mdclk) cyc <= cyc + 1;

    function automatic void expect_at(input int c, input int s, input logic [7:0] e,
                                      input string n);
        exp_t x;
        x.cyc  = c;
        x.sig  = s;
        x.exp  = e;
        x.name = n;
        sb.push_back(x);
    endfunction

    // Monitor: compares every entry due on this cycle; entries left behind count as failures.
    always @(negedge mdclk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                case (sb[i].sig)
                    SIG_RDO:  act = mdrdo;
                    SIG_LOCK: act = {7'b0, lock};
                    SIG_CHG:  act = {7'b0, cfg_changed};
                    SIG_CFG:  act = cfg_data;
`ifdef MDRP_RESPONDER_ERR_EN
                    SIG_ERR:  act = {7'b0, err};
`endif
                    default:  act = 8'hxx;
                endcase
                checks++;
                if (sb[i].cyc != cyc || act !== sb[i].exp) begin
                    failures++;
                    $display("FAIL %s cyc=%0d due=%0d got=%02h want=%02h",
                             sb[i].name, cyc, sb[i].cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic op(input logic [1:0] o, input logic inc, input logic [7:0] d);
        mdopc  = o;
        mdainc = inc;
        mdwdi  = d;
        @(posedge mdclk);
        #1;
        mdopc  = MDRP_OP_NOP;
        mdainc = 1'b0;
        mdwdi  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) op(MDRP_OP_NOP, 1'b0, 8'h00);
    endtask

    task automatic expect_relock(input int start, input string n);
        for (int i = 0; i < 16; i++) expect_at(start + i, SIG_LOCK, 8'h00, n);
        expect_at(start + 16, SIG_LOCK, 8'h01, n);
        expect_at(start + 17, SIG_LOCK, 8'h01, n);
    endtask

    int r;
    int w;

    initial begin
        reset    = 1'b1;
        mdopc    = MDRP_OP_NOP;
        mdainc   = 1'b0;
        mdwdi    = 8'h00;
        cfg_addr = 8'h00;
        repeat (2) @(posedge mdclk);
        #1;
        reset = 1'b0;

        // Reset state and initial lock sequence.
        r = cyc;
        expect_relock(r, "reset_lock");
        expect_at(r, SIG_RDO, 8'h00, "reset_mdrdo");
        expect_at(r + 8, SIG_RDO, 8'h00, "idle_mdrdo");
        expect_at(r + 17, SIG_RDO, 8'h00, "idle_mdrdo_end");
        expect_at(r, SIG_CHG, 8'h00, "reset_chg");
        expect_at(r, SIG_CFG, 8'h00, "reset_cfg");
`ifdef MDRP_RESPONDER_ERR_EN
        expect_at(r, SIG_ERR, 8'h00, "reset_err");
`endif
        idle(20);

        // Write/read with increment, side port and mdrdo hold.
        op(MDRP_OP_SETADDR, 1'b1, 8'h05);
        op(MDRP_OP_WRITE, 1'b1, 8'hA5);
        op(MDRP_OP_WRITE, 1'b1, 8'h5A);
        op(MDRP_OP_SETADDR, 1'b0, 8'h05);
        expect_at(cyc + 1, SIG_RDO, 8'hA5, "read_a5");
        op(MDRP_OP_READ, 1'b1, 8'h00);
        expect_at(cyc + 1, SIG_RDO, 8'h5A, "read_5a");
        op(MDRP_OP_READ, 1'b0, 8'h00);
        cfg_addr = 8'h06;
        expect_at(cyc + 1, SIG_CFG, 8'h5A, "cfg_06");
        expect_at(cyc + 1, SIG_RDO, 8'h5A, "rdo_hold_nop");
        op(MDRP_OP_NOP, 1'b0, 8'h00);
        expect_at(cyc + 1, SIG_CFG, 8'h5A, "cfg_old_on_write");
        expect_at(cyc + 2, SIG_CFG, 8'h11, "cfg_new_after_write");
        expect_at(cyc + 1, SIG_RDO, 8'h5A, "rdo_hold_write");
        op(MDRP_OP_WRITE, 1'b0, 8'h11);
        idle(1);

        // Pointer wrap with out-of-range write dropped; reg 0 primed to expose the wrap.
        op(MDRP_OP_SETADDR, 1'b0, 8'h00);
        op(MDRP_OP_WRITE, 1'b0, 8'hC3);
        op(MDRP_OP_SETADDR, 1'b0, 8'hFF);
        op(MDRP_OP_WRITE, 1'b1, 8'h77);
        expect_at(cyc + 1, SIG_RDO, 8'hC3, "wrap_read_reg0");
`ifdef MDRP_RESPONDER_ERR_EN
        expect_at(cyc + 1, SIG_ERR, 8'h01, "err_oob");
`endif
        op(MDRP_OP_READ, 1'b0, 8'h00);
        cfg_addr = 8'h1F;
        expect_at(cyc + 1, SIG_CFG, 8'h00, "oob_write_no_alias");
        cfg_addr = 8'hFF;
        op(MDRP_OP_NOP, 1'b0, 8'h00);
        expect_at(cyc + 1, SIG_CFG, 8'h00, "cfg_oob");
        op(MDRP_OP_NOP, 1'b0, 8'h00);

        // Commit, then a second commit 5 cycles later restarts the count.
        op(MDRP_OP_SETADDR, 1'b0, 8'h1F);
        w = cyc + 1;
        expect_at(w, SIG_CHG, 8'h01, "commit1_chg");
        expect_at(w + 1, SIG_CHG, 8'h00, "commit1_chg_end");
        for (int i = 0; i < 5; i++) expect_at(w + i, SIG_LOCK, 8'h00, "commit1_lock");
        op(MDRP_OP_WRITE, 1'b0, 8'h01);
        idle(4);
        w = cyc + 1;
        expect_at(w, SIG_CHG, 8'h01, "commit2_chg");
        expect_at(w + 1, SIG_CHG, 8'h00, "commit2_chg_end");
        expect_relock(w, "commit2_lock");
        op(MDRP_OP_WRITE, 1'b0, 8'h01);
        idle(20);

        // Write to commit address with bit0 clear: plain register write.
        w = cyc + 1;
        expect_at(w, SIG_CHG, 8'h00, "nocommit_chg");
        for (int i = 0; i < 3; i++) expect_at(w + i, SIG_LOCK, 8'h01, "nocommit_lock");
        op(MDRP_OP_WRITE, 1'b0, 8'h02);
        cfg_addr = 8'h1F;
        expect_at(cyc + 1, SIG_CFG, 8'h02, "nocommit_cfg");
        expect_at(cyc + 1, SIG_RDO, 8'h02, "nocommit_read");
        op(MDRP_OP_READ, 1'b0, 8'h00);
        idle(2);

        // Reset mid write burst, with a write+increment pending at the reset edge.
        op(MDRP_OP_SETADDR, 1'b0, 8'h00);
        op(MDRP_OP_WRITE, 1'b1, 8'h11);
        op(MDRP_OP_WRITE, 1'b1, 8'h22);
        reset = 1'b1;
        op(MDRP_OP_WRITE, 1'b1, 8'h33);
        reset = 1'b0;
        r = cyc;
        expect_relock(r, "rst2_lock");
        expect_at(r, SIG_RDO, 8'h00, "rst2_mdrdo");
        expect_at(r, SIG_CFG, 8'h00, "rst2_cfg");
`ifdef MDRP_RESPONDER_ERR_EN
        expect_at(r, SIG_ERR, 8'h00, "rst2_err");
`endif
        cfg_addr = 8'h00;
        expect_at(cyc + 1, SIG_CFG, 8'h00, "rst2_reg0");
        op(MDRP_OP_NOP, 1'b0, 8'h00);
        cfg_addr = 8'h01;
        expect_at(cyc + 1, SIG_CFG, 8'h00, "rst2_reg1");
        op(MDRP_OP_NOP, 1'b0, 8'h00);
        cfg_addr = 8'h1F;
        expect_at(cyc + 1, SIG_CFG, 8'h00, "rst2_reg1f");
        op(MDRP_OP_NOP, 1'b0, 8'h00);
        // Pointer must be back at 0: an unaddressed write lands in reg 0.
        op(MDRP_OP_WRITE, 1'b0, 8'h3C);
        cfg_addr = 8'h00;
        expect_at(cyc + 1, SIG_CFG, 8'h3C, "rst2_ptr0");
        op(MDRP_OP_NOP, 1'b0, 8'h00);
        idle(25);

        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain left=%0d", sb.size());
            failures += sb.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdrp_responder.md
Name: mdrp_responder

Overview:
- Responder (PLL-side) end of the PLL dynamic-reconfiguration port (MDRP): mdopc / mdainc / mdwdi in, mdrdo out.
- Holds the 8-bit PLL configuration register file written and read by the PLL init/reconfig initiator.
- Emulates PLL lock behaviour after reset and after a configuration commit.
- Used as the synthesizable stand-in PLL model for simulation and for soft-clock targets, and exposes its registers to local logic through a side read port.

Parameters:
- NUM_REGS, 32, number of implemented 8-bit config registers at addresses 0..NUM_REGS-1.
- COMMIT_ADDR, 8'h1F, register address whose write with bit0=1 triggers relock.
- LOCK_DELAY, 16, mdclk cycles lock stays low after reset release or commit (must be >= 1).

Ports:
- mdclk, in, 1, sole clock; all logic is rising-edge.
- reset, in, 1, synchronous, active-high.
- mdopc, in, 2, opcode: 00 NOP, 01 WRITE, 10 READ, 11 SETADDR.
- mdainc, in, 1, post-increment address after this cycle's WRITE/READ.
- mdwdi, in, 8, write data for WRITE; address for SETADDR.
- mdrdo, out, 8, read data.
- lock, out, 1, emulated PLL lock.
- cfg_changed, out, 1, one-cycle pulse on every accepted commit.
- cfg_addr, in, 8, side read address.
- cfg_data, out, 8, side read data, registered.

Behaviour:
- Reset state:
  - All registers 8'h00; address pointer 8'h00.
  - mdrdo = 0, lock = 0, cfg_changed = 0, cfg_data = 0.
  - FSM = RELOCK with counter = LOCK_DELAY-1.
- Address pointer (ptr, 8 bits):
  - SETADDR loads ptr <= mdwdi; mdainc is ignored on SETADDR.
  - WRITE/READ with mdainc=1 gives ptr <= ptr+1, wrapping 8'hFF -> 8'h00.
- WRITE:
  - ptr < NUM_REGS: reg[ptr] <= mdwdi at this edge.
  - ptr >= NUM_REGS: write is dropped; ptr increment still applies.
- READ:
  - mdrdo <= reg[ptr] (8'h00 if ptr out of range) at this edge; valid the cycle after the READ op. Latency 1.
  - mdrdo holds its value until the next READ. NOP and WRITE do not change mdrdo.
  - READ uses ptr before any increment.
- Lock FSM:
  - RELOCK: lock = 0; counter decrements each cycle; when counter == 0, go to LOCKED next cycle.
  - LOCKED: lock = 1.
  - LOCK_DELAY = N therefore gives exactly N cycles of lock low after reset deasserts or after the commit write edge.
- Commit:
  - A WRITE to ptr == COMMIT_ADDR with mdwdi[0] = 1:
    - the register is written;
    - the FSM goes to RELOCK with counter = LOCK_DELAY-1;
    - cfg_changed = 1 for the following cycle.
  - Accepted in either state. A commit during RELOCK restarts the count.
  - COMMIT_ADDR >= NUM_REGS means commits never fire.
- Register access during RELOCK is fully allowed; only lock is affected.
- Side port: cfg_data <= reg[cfg_addr] each cycle (00 if out of range), 1-cycle latency. On a same-cycle MDRP write it returns the old value.
- Reset asserted mid-sequence overrides everything at that edge, including a pending increment or commit.

Optional Feature:
- Macro: MDRP_RESPONDER_ERR_EN.
- Defined:
  - Adds output err, 1 bit, sticky, reset to 0.
  - err sets on a WRITE or READ with ptr >= NUM_REGS, or a SETADDR while lock = 0.
  - Cleared only by reset.
- Undefined: no err port and no extra logic. All other behaviour is identical.

Decomposition:
- Package mdrp_pkg:
  - opcode constants MDRP_OP_NOP / WRITE / READ / SETADDR;
  - lock FSM state enum (ST_RELOCK, ST_LOCKED);
  - data/address width constant (8).
- One sub-module, mdrp_lock_timer:
  - inputs: mdclk, reset, restart;
  - outputs: lock, done-pulse;
  - parameter LOCK_DELAY.
  - The responder instantiates it and drives restart from commit detect.

Test Plan:
- Release reset, idle -> lock = 0 for exactly 16 cycles, then 1 and stays 1; mdrdo = 00 throughout.
- SETADDR 8'h05, WRITE A5 with mdainc=1, WRITE 5A with mdainc=1, SETADDR 05, READ with mdainc=1, READ -> mdrdo = A5 one cycle after the first READ, 5A one cycle after the second; cfg_addr = 06 gives cfg_data = 5A.
- SETADDR 8'hFF, WRITE 77 with mdainc=1, READ -> write dropped, ptr wraps to 00, mdrdo = 00. With MDRP_RESPONDER_ERR_EN defined, err = 1.
- Locked, SETADDR 1F, WRITE 01 -> cfg_changed pulses one cycle, lock low 16 cycles. A second commit 5 cycles later -> lock low 16 cycles from the second write.
- WRITE 1F with data 02 (bit0 = 0) -> register updated to 02, no relock, no cfg_changed.
- Assert reset for 1 cycle mid-write-burst -> all registers read 00, ptr = 00, lock relock sequence restarts.
